// File: rtl/stopwatch_disp_pkg.sv
// Shared constants for the stopwatch display scanner: segment codes,
// digit slot indices and the decimal-point pattern.
package stopwatch_disp_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low segment codes, bit order gfedcba.
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [1:0] DIG_MIN  = 2'd3;
  localparam logic [1:0] DIG_SMSD = 2'd2;
  localparam logic [1:0] DIG_SLSD = 2'd1;
  localparam logic [1:0] DIG_MS   = 2'd0;

  localparam logic [3:0] DP_MASK = 4'b1010;

endpackage

// File: rtl/stopwatch_display_scan_if.sv
// Connection bundle between the stopwatch core / board pins and the
// display scanner: BCD digits and controls in, registered pin drives out.
interface stopwatch_display_scan_if;
  import stopwatch_disp_pkg::*;

  bcd_t       minutes;
  bcd_t       seconds_msd;
  bcd_t       seconds_lsd;
  bcd_t       ms_msd;
  logic       lap;
  logic       clr;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       hold_active;

  modport master (
    output minutes, seconds_msd, seconds_lsd, ms_msd, lap, clr, blank,
    input  an, seg, dp, hold_active
  );

  modport slave (
    input  minutes, seconds_msd, seconds_lsd, ms_msd, lap, clr, blank,
    output an, seg, dp, hold_active
  );

endinterface

// File: rtl/seg_decode7.sv
// Combinational BCD to active-low seven-segment decoder; any non-decimal
// code renders as a dash.
module seg_decode7
  import stopwatch_disp_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Four-digit common-anode scan driver with guard time, blanking and a lap
// hold that freezes the shown digits while the core keeps counting.
module stopwatch_display_scan
  import stopwatch_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  stopwatch_display_scan_if.slave  io
);

  localparam int            PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    ls_q, ls_d;
  logic          hold_q, hold_d;
  bcd_t [3:0]    snap_q, snap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  bcd_t [3:0]    live;
  bcd_t          digit;
  logic          press;
  logic [6:0]    seg_dec;

  always_comb begin
    live           = '0;
    live[DIG_MIN]  = io.minutes;
    live[DIG_SMSD] = io.seconds_msd;
    live[DIG_SLSD] = io.seconds_lsd;
    live[DIG_MS]   = io.ms_msd;
  end

  assign press = ls_q[0] & ~ls_q[1];
  assign digit = hold_q ? snap_q[idx_q] : live[idx_q];

  seg_decode7 u_dec (
    .bcd (digit),
    .seg (seg_dec)
  );

  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (pcnt_q == PCNT_LAST) begin
      pcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end

    ls_d   = {ls_q[0], io.lap};
    hold_d = hold_q;
    snap_d = snap_q;
    // clr wins over a press landing in the same cycle
    if (io.clr) begin
      hold_d = 1'b0;
    end else if (press) begin
      hold_d = ~hold_q;
      if (!hold_q) snap_d = live;
    end

    // seg/dp follow the slot even while dark so they settle before the anode opens
    an_d = 4'hF;
    if ((32'(pcnt_q) >= GUARD) && !io.blank) an_d = ~(4'b0001 << idx_q);
    seg_d = seg_dec;
    dp_d  = ~DP_MASK[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      idx_q  <= '0;
      ls_q   <= '0;
      hold_q <= 1'b0;
      snap_q <= '0;
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      ls_q   <= ls_d;
      hold_q <= hold_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign io.an          = an_q;
  assign io.seg         = seg_q;
  assign io.dp          = dp_q;
  assign io.hold_active = hold_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Directed plus randomized bench for stopwatch_display_scan, compared
// every cycle against an arithmetic reference of the scan and lap hold.
module tb_stopwatch_display_scan;

  localparam int RDIV = 8;
  localparam int GRD  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  stopwatch_display_scan_if io();

  stopwatch_display_scan #(.REFRESH_DIV(RDIV), .GUARD(GRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Reference: slot position follows from the number of edges since reset,
  // lap presses from the history of sampled lap levels.
  int         m_edges = 0;
  int         m_lap1  = 0;
  int         m_lap2  = 0;
  bit         m_hold  = 1'b0;
  int         m_snap [4] = '{0, 0, 0, 0};
  logic [3:0] exp_an   = 4'hF;
  logic [6:0] exp_seg  = 7'h7F;
  logic       exp_dp   = 1'b1;
  logic       exp_hold = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int pos, slot;
    int live [4];
    int src  [4];
    if (!rst_n) begin
      m_edges  = 0;
      m_lap1   = 0;
      m_lap2   = 0;
      m_hold   = 1'b0;
      m_snap   = '{0, 0, 0, 0};
      exp_an   = 4'hF;
      exp_seg  = 7'h7F;
      exp_dp   = 1'b1;
      exp_hold = 1'b0;
    end else begin
      live[3] = int'(io.minutes);
      live[2] = int'(io.seconds_msd);
      live[1] = int'(io.seconds_lsd);
      live[0] = int'(io.ms_msd);
      pos  = m_edges % RDIV;
      slot = (m_edges / RDIV) % 4;
      for (int i = 0; i < 4; i++) src[i] = m_hold ? m_snap[i] : live[i];
      exp_an = 4'hF;
      if (pos >= GRD && !io.blank) exp_an[slot] = 1'b0;
      exp_seg = seg_tab[src[slot]];
      exp_dp  = !(slot == 1 || slot == 3);
      if (io.clr) begin
        m_hold = 1'b0;
      end else if (m_lap1 == 1 && m_lap2 == 0) begin
        if (!m_hold) m_snap = live;
        m_hold = !m_hold;
      end
      exp_hold = m_hold;
      m_lap2   = m_lap1;
      m_lap1   = int'(io.lap);
      m_edges++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("an",   32'(io.an),          32'(exp_an));
      chk("seg",  32'(io.seg),         32'(exp_seg));
      chk("dp",   32'(io.dp),          32'(exp_dp));
      chk("hold", 32'(io.hold_active), 32'(exp_hold));
    end
  endtask

  task automatic set_digits(input int m, input int sm, input int sl, input int ms);
    io.minutes     = 4'(m);
    io.seconds_msd = 4'(sm);
    io.seconds_lsd = 4'(sl);
    io.ms_msd      = 4'(ms);
  endtask

  initial begin
    set_digits(3, 4, 5, 6);
    io.lap   = 1'b0;
    io.clr   = 1'b0;
    io.blank = 1'b0;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an",   32'(io.an),          32'h0F);
    chk("rst_seg",  32'(io.seg),         32'h7F);
    chk("rst_dp",   32'(io.dp),          32'h1);
    chk("rst_hold", 32'(io.hold_active), 32'h0);
    rst_n = 1'b1;

    // basic scan with digits 3/4/5/6
    step(1);
    chk("first_dark", 32'(io.an), 32'h0F);
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (io.an === 4'hB) chk("seg_digit4", 32'(io.seg), 32'h19);
      if (io.an === 4'h7 || io.an === 4'hD) chk("dp_lit", 32'(io.dp), 32'h0);
    end

    // lap freeze
    set_digits(1, 2, 3, 4);
    step(3);
    io.lap = 1'b1;
    step(1);
    chk("lap_k", 32'(io.hold_active), 32'h0);
    step(1);
    chk("lap_k1", 32'(io.hold_active), 32'h1);
    set_digits(9, 5, 9, 9);
    step(3);
    io.lap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (io.an === 4'hE) chk("frozen_ms", 32'(io.seg), 32'h19);
    end
    io.lap = 1'b1;
    step(2);
    chk("unlap", 32'(io.hold_active), 32'h0);
    step(3);
    io.lap = 1'b0;
    step(32);

    // clr beats a simultaneous press while held
    io.lap = 1'b1;
    step(3);
    io.lap = 1'b0;
    step(3);
    chk("held_again", 32'(io.hold_active), 32'h1);
    io.lap = 1'b1;
    step(1);
    io.clr = 1'b1;
    step(1);
    io.clr = 1'b0;
    chk("clr_prio", 32'(io.hold_active), 32'h0);
    step(3);
    chk("clr_noretoggle", 32'(io.hold_active), 32'h0);
    io.lap = 1'b0;
    step(8);

    // blanking keeps the scan running
    io.blank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("blank_an", 32'(io.an), 32'h0F);
    end
    io.blank = 1'b0;
    step(40);

    // out-of-range digit shows a dash
    set_digits(12, 0, 7, 8);
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (io.an === 4'h7) chk("dash", 32'(io.seg), 32'h3F);
    end

    // randomized run
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0)
        set_digits(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 5) == 0) io.lap = ~io.lap;
      io.clr   = ($urandom_range(0, 31) == 0);
      io.blank = ($urandom_range(0, 9) == 0);
      step(1);
    end
    io.clr   = 1'b0;
    io.blank = 1'b0;
    io.lap   = 1'b0;
    set_digits(7, 1, 2, 0);
    step(13);

    // asynchronous reset mid-slot
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an",   32'(io.an),          32'h0F);
    chk("arst_seg",  32'(io.seg),         32'h7F);
    chk("arst_hold", 32'(io.hold_active), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(GRD);
    chk("restart_dark", 32'(io.an), 32'h0F);
    step(1);
    chk("restart_idx0", 32'(io.an), 32'h0E);
    step(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
